// File: rtl/vdc_video_ng.sv
// -----------------------------------------------------------------------------
// vdc_video_ng: character-cell pixel serialiser for a VDC-style text display.
//
// A cell is fetched on newCol (attribute + glyph byte), decoded into an 8-bit
// bitmap (cursor, blink, underline and reverse applied), then shifted out
// MSB-first, one pixel per enable or per two enables when pixel-doubled. Pixels
// past the displayed width form an inter-character gap. The first cell after
// visible rises can drop its leading pixels for horizontal smooth scrolling.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   enable                pixel-clock enable; everything holds while low
//   reg_*                 display configuration registers
//   newCol, visible,      raster timing from the CRTC side
//   blank, blink, col,
//   line, dispaddr
//   attr_in, char_in      attribute and glyph byte, valid with newCol
//   rgbi                  registered pixel colour
//   crs_out               cursor active in the cell being shifted
// -----------------------------------------------------------------------------
module vdc_video_ng #(
    parameter int unsigned CELL_MAX = 16,
    parameter int unsigned COL_OFS  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  reg_cth,
    input  logic [3:0]  reg_cdh,
    input  logic [3:0]  reg_hss,
    input  logic        reg_dbl,
    input  logic        reg_text,
    input  logic        reg_atr,
    input  logic        reg_semi,
    input  logic        reg_rvs,
    input  logic        reg_cbrate,
    input  logic [3:0]  reg_fg,
    input  logic [3:0]  reg_bg,
    input  logic [4:0]  reg_ul,
    input  logic [1:0]  reg_cm,
    input  logic [4:0]  reg_cs,
    input  logic [4:0]  reg_ce,
    input  logic [15:0] reg_cp,
    input  logic        newCol,
    input  logic        visible,
    input  logic        blank,
    input  logic [1:0]  blink,
    input  logic [7:0]  col,
    input  logic [4:0]  line,
    input  logic [15:0] dispaddr,
    input  logic [7:0]  attr_in,
    input  logic [7:0]  char_in,
    output logic [3:0]  rgbi,
    output logic        crs_out
);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} state_e;

    state_e      state_q, state_d;
    logic [7:0]  attr_q, attr_d;
    logic [7:0]  char_q, char_d;
    logic [7:0]  bitmap_q, bitmap_d;
    logic        crs_q, crs_d;
    logic        rev_q, rev_d;
    logic        ul_q, ul_d;
    logic        last_q, last_d;
    logic [4:0]  pcnt_q, pcnt_d;
    logic        dcnt_q, dcnt_d;
    logic        hss_pend_q, hss_pend_d;
    logic        vis_q, vis_d;
    logic [3:0]  rgbi_q, rgbi_d;

    // Attribute decode and cell geometry
    logic [3:0]  fg, bg;
    logic [2:0]  ca;
    logic [7:0]  vcol;
    logic        underflow;
    logic [3:0]  cdh_eff;
    logic [4:0]  shift_len, total_len, pcnt_inc;
    logic        has_gap, px_step;

    // LOAD-time bitmap construction
    logic [15:0] cur_addr;
    logic        cm_ok, crs_now, ul_now, rev_now, fill_now, shift_fill;
    logic [7:0]  raw_now, bm_now, bm_load;
    logic [3:0]  skip;
    logic [23:0] pre_shift;
    logic        pix;

    always_comb begin
        vcol      = col - 8'(COL_OFS);
        // Columns left of the visible window wrap to the top of the range.
        underflow = ({1'b0, vcol} >= 9'(256 - COL_OFS));

        fg = reg_atr ? attr_q[3:0] : reg_fg;
        bg = (reg_text & reg_atr) ? attr_q[7:4] : reg_bg;
        ca = (~reg_text & reg_atr) ? attr_q[6:4] : 3'b000;

        cdh_eff   = (reg_cdh < reg_cth) ? reg_cdh : reg_cth;
        shift_len = {1'b0, cdh_eff} + 5'd1;
        if (shift_len > 5'(CELL_MAX)) shift_len = 5'(CELL_MAX);
        total_len = {1'b0, reg_cth} + 5'd1;
        if (total_len > 5'(CELL_MAX)) total_len = 5'(CELL_MAX);
        has_gap   = (total_len > shift_len);

        // With doubling, the pixel advances on every second enable.
        px_step  = ~reg_dbl | dcnt_q;
        pcnt_inc = pcnt_q + 5'd1;
    end

    always_comb begin
        cur_addr = dispaddr + {8'h00, vcol};
        cm_ok    = (reg_cm == 2'b00) | (reg_cm[1] & blink[reg_cm[0]]);
        crs_now  = ~reg_text & (cur_addr == reg_cp) & cm_ok
                   & (line >= reg_cs) & (line <= reg_ce);
        ul_now   = ca[1] & (line == reg_ul);

        if (ca[0] & blink[reg_cbrate]) begin
            raw_now = 8'h00;
        end else if (ul_now) begin
            raw_now = 8'hFF;
        end else begin
            raw_now = char_q;
        end

        rev_now  = reg_rvs ^ ca[2] ^ crs_now;
        bm_now   = rev_now ? ~raw_now : raw_now;
        fill_now = reg_semi ? bm_now[0] : rev_now;

        // Smooth-scroll pixels are dropped by pre-shifting the glyph.
        skip      = hss_pend_q ? reg_hss : 4'd0;
        pre_shift = {bm_now, {16{fill_now}}} << skip;
        bm_load   = ul_now ? bm_now : pre_shift[23:16];

        shift_fill = reg_semi ? bitmap_q[0] : rev_q;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!visible) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (newCol) state_d = StLoad;
                StLoad:  state_d = StShift;
                StShift: begin
                    if (newCol) begin
                        state_d = StLoad;
                    end else if (px_step && (pcnt_inc >= shift_len)) begin
                        state_d = has_gap ? StGap : StIdle;
                    end
                end
                StGap: begin
                    if (newCol) begin
                        state_d = StLoad;
                    end else if (px_step && (pcnt_inc >= total_len)) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output logic
    always_comb begin
        pix     = 1'b0;
        crs_out = 1'b0;
        case (state_q)
            StShift: begin
                pix     = bitmap_q[7];
                crs_out = crs_q;
            end
            StGap: begin
                pix     = reg_semi ? last_q : rev_q;
                crs_out = crs_q;
            end
            default: ;
        endcase
    end

    // Datapath next state
    always_comb begin
        attr_d     = attr_q;
        char_d     = char_q;
        bitmap_d   = bitmap_q;
        crs_d      = crs_q;
        rev_d      = rev_q;
        ul_d       = ul_q;
        last_d     = last_q;
        pcnt_d     = pcnt_q;
        dcnt_d     = dcnt_q;
        hss_pend_d = hss_pend_q;
        vis_d      = visible;

        if (state_d == StLoad) begin
            attr_d = underflow ? 8'h00 : attr_in;
            char_d = char_in;
        end

        case (state_q)
            StLoad: begin
                bitmap_d   = bm_load;
                crs_d      = crs_now;
                rev_d      = rev_now;
                ul_d       = ul_now;
                pcnt_d     = {1'b0, skip};
                dcnt_d     = 1'b0;
                hss_pend_d = 1'b0;
            end
            StShift: begin
                last_d = bitmap_q[7];
                dcnt_d = reg_dbl & ~dcnt_q;
                if (px_step) begin
                    pcnt_d = pcnt_inc;
                    if (!ul_q) bitmap_d = {bitmap_q[6:0], shift_fill};
                end
            end
            StGap: begin
                dcnt_d = reg_dbl & ~dcnt_q;
                if (px_step) pcnt_d = pcnt_inc;
            end
            default: ;
        endcase

        if (visible && !vis_q) hss_pend_d = 1'b1;

        if (visible) begin
            rgbi_d = pix ? fg : bg;
        end else begin
            rgbi_d = blank ? 4'h0 : reg_bg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            attr_q     <= 8'h00;
            char_q     <= 8'h00;
            bitmap_q   <= 8'h00;
            crs_q      <= 1'b0;
            rev_q      <= 1'b0;
            ul_q       <= 1'b0;
            last_q     <= 1'b0;
            pcnt_q     <= 5'd0;
            dcnt_q     <= 1'b0;
            hss_pend_q <= 1'b1;
            vis_q      <= 1'b0;
            rgbi_q     <= 4'h0;
        end else if (enable) begin
            attr_q     <= attr_d;
            char_q     <= char_d;
            bitmap_q   <= bitmap_d;
            crs_q      <= crs_d;
            rev_q      <= rev_d;
            ul_q       <= ul_d;
            last_q     <= last_d;
            pcnt_q     <= pcnt_d;
            dcnt_q     <= dcnt_d;
            hss_pend_q <= hss_pend_d;
            vis_q      <= vis_d;
            rgbi_q     <= rgbi_d;
        end
    end

    assign rgbi = rgbi_q;

endmodule

// File: tb/tb_vdc_video_ng.sv
// -----------------------------------------------------------------------------
// tb_vdc_video_ng: self-checking bench for vdc_video_ng. Each scenario pushes
// the expected rgbi stream into a scoreboard queue as it drives a cell, then
// pops one entry per enable cycle and compares it with the DUT output.
// -----------------------------------------------------------------------------
module tb_vdc_video_ng;

    localparam int unsigned COL_OFS = 8;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [3:0]  reg_cth, reg_cdh, reg_hss;
    logic        reg_dbl, reg_text, reg_atr, reg_semi, reg_rvs, reg_cbrate;
    logic [3:0]  reg_fg, reg_bg;
    logic [4:0]  reg_ul;
    logic [1:0]  reg_cm;
    logic [4:0]  reg_cs, reg_ce;
    logic [15:0] reg_cp;
    logic        newCol, visible, blank;
    logic [1:0]  blink;
    logic [7:0]  col;
    logic [4:0]  line;
    logic [15:0] dispaddr;
    logic [7:0]  attr_in, char_in;
    logic [3:0]  rgbi;
    logic        crs_out;

    logic [3:0]  sb[$];
    int          checks = 0;
    int          passed = 0;

    vdc_video_ng #(.CELL_MAX(16), .COL_OFS(COL_OFS)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .reg_cth(reg_cth), .reg_cdh(reg_cdh), .reg_hss(reg_hss), .reg_dbl(reg_dbl),
        .reg_text(reg_text), .reg_atr(reg_atr), .reg_semi(reg_semi), .reg_rvs(reg_rvs),
        .reg_cbrate(reg_cbrate), .reg_fg(reg_fg), .reg_bg(reg_bg), .reg_ul(reg_ul),
        .reg_cm(reg_cm), .reg_cs(reg_cs), .reg_ce(reg_ce), .reg_cp(reg_cp),
        .newCol(newCol), .visible(visible), .blank(blank), .blink(blink), .col(col),
        .line(line), .dispaddr(dispaddr), .attr_in(attr_in), .char_in(char_in),
        .rgbi(rgbi), .crs_out(crs_out)
    );

    always #5 clk = ~clk;

    // Expected-stream builders: glyph bits MSB-first (each repeated rep times)
    // and runs of a constant colour.
    task automatic push_bits(input logic [7:0] b, input int n, input int rep,
                             input logic [3:0] f, input logic [3:0] k);
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r < rep; r++) sb.push_back(b[7-i] ? f : k);
        end
    endtask

    task automatic push_val(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) sb.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        step();
        step();
        checks++;
        if (rgbi !== 4'h0) $display("FAIL reset_rgbi: got %0h want 0", rgbi);
        else passed++;
        checks++;
        if (crs_out !== 1'b0) $display("FAIL reset_crs: got %0b want 0", crs_out);
        else passed++;
        reset  = 1'b0;
        enable = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [3:0] exp;
        int n;
        push_val(4'h0, 2);
        push_bits(8'hA5, 8, 1, 4'h1, 4'h0);
        push_val(4'h0, 2);
        n = sb.size();
        newCol  = 1'b1;
        char_in = 8'hA5;
        for (int i = 0; i < n; i++) begin
            step();
            newCol = 1'b0;
            exp = sb.pop_front();
            checks++;
            if (rgbi !== exp) $display("FAIL basic px%0d: got %0h want %0h", i, rgbi, exp);
            else passed++;
        end
    endtask

    task automatic test_gap();
        logic [3:0] exp;
        int n;
        reg_cth = 4'd9;
        for (int pass = 0; pass < 2; pass++) begin
            reg_semi = (pass == 1);
            push_val(4'h0, 2);
            if (pass == 0) begin
                push_bits(8'hA5, 8, 1, 4'h1, 4'h0);
                push_val(4'h0, 2);
            end else begin
                push_bits(8'h01, 8, 1, 4'h1, 4'h0);
                push_val(4'h1, 2);
            end
            push_val(4'h0, 2);
            n = sb.size();
            newCol  = 1'b1;
            char_in = (pass == 0) ? 8'hA5 : 8'h01;
            for (int i = 0; i < n; i++) begin
                step();
                newCol = 1'b0;
                exp = sb.pop_front();
                checks++;
                if (rgbi !== exp)
                    $display("FAIL gap%0d px%0d: got %0h want %0h", pass, i, rgbi, exp);
                else passed++;
            end
        end
        reg_cth  = 4'd7;
        reg_semi = 1'b0;
    endtask

    task automatic test_double();
        logic [3:0] exp;
        int n;
        reg_dbl = 1'b1;
        push_val(4'h0, 2);
        push_bits(8'h80, 8, 2, 4'h1, 4'h0);
        push_val(4'h0, 2);
        n = sb.size();
        newCol  = 1'b1;
        char_in = 8'h80;
        for (int i = 0; i < n; i++) begin
            step();
            newCol = 1'b0;
            exp = sb.pop_front();
            checks++;
            if (rgbi !== exp) $display("FAIL double px%0d: got %0h want %0h", i, rgbi, exp);
            else passed++;
        end
        reg_dbl = 1'b0;
    endtask

    task automatic test_cursor();
        logic [3:0] exp;
        int n;
        reg_cm = 2'b00;
        reg_cs = 5'd1;
        reg_ce = 5'd5;
        reg_cp = 16'h0105;   // dispaddr 0x0100 + vcol 5
        for (int pass = 0; pass < 2; pass++) begin
            line = (pass == 0) ? 5'd3 : 5'd6;
            push_val(4'h0, 2);
            push_bits((pass == 0) ? 8'hFF : 8'h0F, 8, 1, 4'h1, 4'h0);
            push_val(4'h0, 1);
            n = sb.size();
            newCol  = 1'b1;
            char_in = (pass == 0) ? 8'h00 : 8'h0F;
            for (int i = 0; i < n; i++) begin
                step();
                newCol = 1'b0;
                exp = sb.pop_front();
                checks++;
                if (rgbi !== exp)
                    $display("FAIL cursor%0d px%0d: got %0h want %0h", pass, i, rgbi, exp);
                else passed++;
                if (i == 4 || i == n - 1) begin
                    checks++;
                    if (crs_out !== (pass == 0 && i == 4))
                        $display("FAIL cursor%0d crs@%0d: got %0b want %0b", pass, i, crs_out,
                                 (pass == 0 && i == 4));
                    else passed++;
                end
            end
        end
        line   = 5'd3;
        reg_cm = 2'b01;
    endtask

    task automatic test_blanking();
        visible = 1'b0;
        blank   = 1'b0;
        reg_bg  = 4'h5;
        step();
        checks++;
        if (rgbi !== 4'h5) $display("FAIL border: got %0h want 5", rgbi);
        else passed++;
        blank = 1'b1;
        step();
        checks++;
        if (rgbi !== 4'h0) $display("FAIL blank: got %0h want 0", rgbi);
        else passed++;
        reg_bg  = 4'h0;
        blank   = 1'b0;
        visible = 1'b1;
        step();
    endtask

    task automatic test_hss();
        logic [3:0] exp;
        int n;
        visible = 1'b0;
        step();
        step();
        reg_hss = 4'd3;
        for (int pass = 0; pass < 2; pass++) begin
            push_val(4'h0, 2);
            if (pass == 0) push_bits(8'h80, 5, 1, 4'h1, 4'h0);
            else           push_bits(8'hF0, 8, 1, 4'h1, 4'h0);
            push_val(4'h0, 2);
            n = sb.size();
            visible = 1'b1;
            newCol  = 1'b1;
            char_in = 8'hF0;
            for (int i = 0; i < n; i++) begin
                step();
                newCol = 1'b0;
                exp = sb.pop_front();
                checks++;
                if (rgbi !== exp)
                    $display("FAIL hss%0d px%0d: got %0h want %0h", pass, i, rgbi, exp);
                else passed++;
            end
        end
        reg_hss = 4'd0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        int n;
        push_val(4'h0, 2);
        push_bits(8'hA5, 5, 1, 4'h1, 4'h0);
        push_val(4'h0, 1);
        push_bits(8'hC3, 8, 1, 4'h1, 4'h0);
        push_val(4'h0, 1);
        n = sb.size();
        newCol  = 1'b1;
        char_in = 8'hA5;
        for (int i = 0; i < n; i++) begin
            step();
            exp = sb.pop_front();
            checks++;
            if (rgbi !== exp) $display("FAIL abort px%0d: got %0h want %0h", i, rgbi, exp);
            else passed++;
            // Interrupt the first cell while its fifth pixel is being shifted.
            newCol = (i == 5);
            if (i == 5) char_in = 8'hC3;
        end
    endtask

    task automatic test_reset_mid();
        reg_bg = 4'h3;
        reg_cm = 2'b00;
        newCol  = 1'b1;
        char_in = 8'hA5;
        step();
        newCol = 1'b0;
        step();
        step();
        step();
        checks++;
        if (crs_out !== 1'b1) $display("FAIL rstmid_crs_before: got %0b want 1", crs_out);
        else passed++;
        reset  = 1'b1;
        enable = 1'b0;
        step();
        checks++;
        if (rgbi !== 4'h0) $display("FAIL rstmid_rgbi: got %0h want 0", rgbi);
        else passed++;
        checks++;
        if (crs_out !== 1'b0) $display("FAIL rstmid_crs: got %0b want 0", crs_out);
        else passed++;
        reset  = 1'b0;
        enable = 1'b1;
        step();
        checks++;
        if (rgbi !== 4'h3) $display("FAIL rstmid_idle: got %0h want 3", rgbi);
        else passed++;
        reg_bg = 4'h0;
        reg_cm = 2'b01;
        step();
    endtask

    task automatic test_underflow();
        logic [3:0] exp;
        int n;
        reg_atr = 1'b1;
        reg_bg  = 4'h2;
        attr_in = 8'h0C;
        for (int pass = 0; pass < 2; pass++) begin
            col = (pass == 0) ? 8'(COL_OFS + 1) : 8'(COL_OFS - 1);
            push_val(4'h2, 2);
            push_bits(8'hFF, 8, 1, (pass == 0) ? 4'hC : 4'h0, 4'h2);
            push_val(4'h2, 1);
            n = sb.size();
            newCol  = 1'b1;
            char_in = 8'hFF;
            for (int i = 0; i < n; i++) begin
                step();
                newCol = 1'b0;
                exp = sb.pop_front();
                checks++;
                if (rgbi !== exp)
                    $display("FAIL underflow%0d px%0d: got %0h want %0h", pass, i, rgbi, exp);
                else passed++;
            end
        end
        reg_atr = 1'b0;
        reg_bg  = 4'h0;
        attr_in = 8'h00;
        col     = 8'(COL_OFS + 5);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0;
        reg_cth = 4'd7; reg_cdh = 4'd7; reg_hss = 4'd0; reg_dbl = 1'b0;
        reg_text = 1'b0; reg_atr = 1'b0; reg_semi = 1'b0; reg_rvs = 1'b0;
        reg_cbrate = 1'b0; reg_fg = 4'h1; reg_bg = 4'h0; reg_ul = 5'd31;
        reg_cm = 2'b01; reg_cs = 5'd0; reg_ce = 5'd0; reg_cp = 16'hFFFF;
        newCol = 1'b0; visible = 1'b1; blank = 1'b0; blink = 2'b00;
        col = 8'(COL_OFS + 5); line = 5'd3; dispaddr = 16'h0100;
        attr_in = 8'h00; char_in = 8'h00;

        test_reset();
        test_basic();
        test_gap();
        test_double();
        test_cursor();
        test_blanking();
        test_hss();
        test_back_to_back();
        test_reset_mid();
        test_underflow();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/vdc_video_ng.md
VDC_VIDEO_NG -- requirements
Module: vdc_video_ng

Interface
REQ-001 SHALL have parameter CELL_MAX, default 16; maximum character-cell width in pixels (8..16).
REQ-002 SHALL have parameter COL_OFS, default 8; column count subtracted from col to form the visible column index vcol.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: pixel-clock enable; all state holds when low.
REQ-006 SHALL have ports reg_cth[3:0] (cell total width-1), reg_cdh[3:0] (displayed pixels-1), reg_hss[3:0] (horizontal smooth scroll), reg_dbl[1] (pixel double), all inputs.
REQ-007 SHALL have inputs reg_text, reg_atr, reg_semi, reg_rvs, reg_cbrate (1 bit each); reg_fg[3:0], reg_bg[3:0], reg_ul[4:0].
REQ-008 SHALL have cursor inputs reg_cm[1:0], reg_cs[4:0], reg_ce[4:0], reg_cp[15:0].
REQ-009 SHALL have timing inputs newCol, visible, blank, blink[1:0] (1 bit each except blink); col[7:0]; line[4:0]; dispaddr[15:0].
REQ-010 SHALL have data inputs attr_in[7:0] and char_in[7:0]: attribute and glyph byte for vcol, valid on the newCol cycle.
REQ-011 SHALL have outputs rgbi[3:0] (pixel colour) and crs_out (1 bit; cursor active in current cell).

Function
REQ-012 Attribute decode SHALL be fg=reg_atr?attr[3:0]:reg_fg; bg=(reg_text&reg_atr)?attr[7:4]:reg_bg; ca=(~reg_text&reg_atr)?attr[6:4]:0. Decode SHALL use the attribute latched at LOAD.
REQ-013 State machine SHALL have states IDLE, LOAD, SHIFT, GAP; each transition occurs only on enable cycles.
REQ-014 IDLE->LOAD on newCol&visible; LOAD SHALL last one enable cycle, latch attr_in/char_in, and compute crs and bitmap.
REQ-015 crs SHALL be set when ~reg_text, dispaddr+vcol==reg_cp (16-bit wrap), (reg_cm==0 or (reg_cm[1]&blink[reg_cm[0]])), and reg_cs<=line<=reg_ce.
REQ-016 Bitmap SHALL be 0x00 if ca[0]&blink[reg_cbrate]; else 0xFF if ca[1]&line==reg_ul; else char_in. Bitmap SHALL be inverted when reg_rvs^ca[2]^crs.
REQ-017 LOAD->SHIFT. SHIFT SHALL emit bitmap MSB-first, one pixel per enable, or per two enables when reg_dbl=1.
REQ-018 Shift fill bit SHALL be bitmap[0] when reg_semi, else the reverse flag. No shift SHALL occur while the underline condition holds.
REQ-019 SHIFT SHALL emit min(reg_cdh,reg_cth)+1 pixels (clamped), then enter GAP for reg_cth-reg_cdh pixels; skip GAP when this value is <=0.
REQ-020 GAP pixels SHALL output the last shifted bit when reg_semi, else the reverse-flag colour (fg if reverse, else bg).
REQ-021 On the first cell after visible rises, the first reg_hss pixels of SHIFT SHALL be discarded (not output) and counted against the cell width.
REQ-022 newCol arriving in SHIFT/GAP SHALL abort the cell and enter LOAD the same cycle; end of GAP without newCol SHALL go to IDLE.
REQ-023 rgbi SHALL be registered, with latency 1 enable cycle: visible ? (pixel?fg:bg) : blank ? 0 : reg_bg.
REQ-024 visible falling SHALL force IDLE next enable cycle.
REQ-025 If vcol>=256-COL_OFS (underflow), attributes SHALL be treated as 0x00.
REQ-026 crs_out SHALL equal latched crs while in SHIFT/GAP, else 0.

Reset
REQ-027 Reset SHALL force state IDLE, rgbi=0, crs_out=0, bitmap=0, pixel/double counters=0, hss-pending=1; reset overrides enable and any in-flight cell.

Verification
REQ-028 reg_cdh=7, reg_cth=7, reg_dbl=0, char 0xA5, fg=1, bg=0 -> rgbi 1,0,1,0,0,1,0,1 starting one enable after LOAD.
REQ-029 Same setup with reg_cth=9, reg_semi=0, reg_rvs=0 -> 8 pixels, then 2 bg pixels, then IDLE.
REQ-030 reg_dbl=1, char 0x80 -> rgbi=fg for 2 cycles, then bg for 14 cycles.
REQ-031 Cursor at dispaddr+vcol==reg_cp, reg_cm=0, line within cs..ce, char 0x00 -> 8 fg pixels, crs_out=1.
REQ-032 reg_hss=3, first cell after visible, char 0xF0 -> output begins 1,0,0,0,0 (5 pixels).
REQ-033 newCol mid-SHIFT at pixel 4 -> new glyph starts next cycle; reset mid-cell -> rgbi=0 next cycle.
